mpu_op_sequencer: RTL and testbench
===================================

Name: mpu_op_sequencer

Overview:
Top-level sequencer for one matrix-multiply operation in the MPU. It accepts a command, starts the dispatcher, and waits for dispatch to finish. It then waits for the FMA cluster to drain, triggers the result collector, and reports done, abort or timeout to the host side. It sits between the command interface and the dispatcher/collector pair, and monitors the cluster busy flags.

Parameters:
DRAIN_CYCLES, 4, consecutive cluster-idle cycles required before collection starts (legal range 1..255)
TIMEOUT, 1024, max cycles in any single wait state before ERROR (legal range 2..65535)
TAGW, 4, command tag width

Ports:
clk  in  1  clock
rst  in  1  reset
cmd_valid_in  in  1  command request
cmd_tag_in  in  TAGW  command identifier
cmd_ready_out  out  1  sequencer can accept a command
abort_in  in  1  abort current operation / clear error
disp_start_out  out  1  start request to dispatcher
disp_ack_in  in  1  dispatcher has left idle
disp_finished_in  in  1  dispatcher finished issuing floats
cluster_busy_in  in  8  busy flags of the 8 FMA units (bit set = busy)
coll_start_out  out  1  start request to collector
coll_done_in  in  1  collector has written all results
done_out  out  1  one-cycle completion pulse
done_tag_out  out  TAGW  tag of completed/errored command
error_out  out  1  timeout error flag
op_count_out  out  16  completed-operation count
state_out  out  3  current state (debug)

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock. On reset: state=SEQ_IDLE, cmd_ready_out=1, every other output 0, tag register 0, all counters 0.
- Outputs are Moore-decoded from the registered state. Counters and the tag are registered. There is no combinational path from inputs to outputs.
- State encoding on state_out: IDLE=0, START=1, DISPATCH=2, DRAIN=3, COLLECT=4, DONE=5, ERROR=6.
- IDLE:
  - cmd_ready_out=1.
  - If cmd_valid_in=1, latch cmd_tag_in and go to START.
  - cmd_valid_in is ignored in every other state.
- START:
  - disp_start_out=1.
  - If disp_ack_in=1, go to DISPATCH.
- DISPATCH:
  - disp_start_out=0.
  - If disp_finished_in=1, go to DRAIN and clear the drain counter.
  - If disp_ack_in and disp_finished_in are both sampled high in START, go to DISPATCH first; finish is handled on the next cycle.
- DRAIN:
  - The drain counter increments on each cycle with cluster_busy_in==0.
  - Any busy bit set clears the drain counter to 0.
  - If cluster_busy_in==0 and the counter == DRAIN_CYCLES-1, go to COLLECT. With DRAIN_CYCLES=4, COLLECT is entered after exactly 4 consecutive idle cycles.
- COLLECT:
  - coll_start_out=1, held until coll_done_in=1.
  - On coll_done_in=1, go to DONE.
- DONE:
  - done_out=1 for exactly one cycle; done_tag_out=latched tag.
  - op_count_out increments, saturating at 0xFFFF.
  - Go to IDLE.
- ERROR:
  - error_out=1 and done_tag_out=latched tag, both held.
  - All other handshake outputs are 0.
  - Leave ERROR only via abort_in or rst.
- Watchdog:
  - A 16-bit counter runs in START, DISPATCH, DRAIN and COLLECT.
  - It clears on every state change.
  - If it reaches TIMEOUT-1 while the state is unchanged, go to ERROR next cycle.
  - The DRAIN state's counter clearing on a busy bit does not reset the watchdog.
- abort_in: in any state except IDLE, go to IDLE next cycle, clear error_out, and clear the drain and watchdog counters. op_count_out is not incremented. abort_in is ignored in IDLE.
- Transition priority: rst > abort_in > watchdog timeout > normal transition.
- Reset mid-operation: same as a reset from idle. There is no pending-command memory.
- done_tag_out keeps its last value outside DONE/ERROR. Only rst clears it.

Test Plan:
- Nominal flow, no stall:
  - Stimulus: rst, then cmd_valid with tag=0x5; disp_ack 1 cycle after START; disp_finished 10 cycles later; cluster_busy=0x00 throughout; coll_done 3 cycles after coll_start.
  - Required: state sequence 0→1→2→3→4→5→0; disp_start high exactly 1 cycle; DRAIN lasts 4 cycles; done_out pulses 1 cycle with done_tag_out=0x5; op_count_out=1.
- Drain restart:
  - Stimulus: in DRAIN, cluster_busy_in=0x00,0x00,0x00,0x10,0x00×4.
  - Required: COLLECT entered only after the final 4 idle cycles, i.e. 8 cycles after entering DRAIN.
- Timeout:
  - Stimulus: TIMEOUT=16; disp_ack never asserted.
  - Required: ERROR after 16 cycles in START; error_out=1 and disp_start_out=0; cmd_ready_out=0 until abort_in.
  - Then pulse abort_in: next cycle IDLE, error_out=0, op_count_out unchanged.
- Abort mid-collect:
  - Stimulus: abort_in asserted in the same cycle as coll_done_in.
  - Required: next state IDLE, no done_out pulse, op_count_out unchanged.
- Busy commands ignored:
  - Stimulus: cmd_valid_in held high with tag=0x3 during a tag=0x9 operation.
  - Required: done_tag_out=0x9; the tag=0x3 command is accepted only when back in IDLE, and completes as a second op with op_count_out=2.
- Reset mid-operation:
  - Stimulus: rst asserted in DRAIN.
  - Required: next cycle all outputs at reset values; cmd_ready_out=1, op_count_out=0.

Source files
------------

// File: rtl/mpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// mpu_op_sequencer
//   Top-level sequencer for one matrix-multiply operation. It accepts a
//   command, starts the dispatcher, and waits for dispatch to finish. It then
//   waits for the FMA cluster to go idle for DRAIN_CYCLES consecutive cycles,
//   triggers the result collector, and reports done, abort or timeout.
//
// Handshakes: each *_start_out is a level request held for the whole of its
//   state. The partner answers with a level/pulse (disp_ack_in,
//   disp_finished_in, coll_done_in) that is sampled on the rising clock edge.
//   All outputs decode from registered state, so no input reaches an output
//   combinationally.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid_in      command request (sampled only in IDLE)
//   cmd_tag_in        command identifier
//   cmd_ready_out     high in IDLE
//   abort_in          abort current operation / clear error
//   disp_start_out    start request to dispatcher (START state)
//   disp_ack_in       dispatcher has left idle
//   disp_finished_in  dispatcher finished issuing floats
//   cluster_busy_in   busy flags of the 8 FMA units
//   coll_start_out    start request to collector (COLLECT state)
//   coll_done_in      collector has written all results
//   done_out          one-cycle completion pulse
//   done_tag_out      tag of the last completed/errored command
//   error_out         timeout error flag, held until abort/reset
//   op_count_out      saturating completed-operation count
//   state_out         current state (debug)
// ---------------------------------------------------------------------------
module mpu_op_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 1024,
  parameter int TAGW         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid_in,
  input  logic [TAGW-1:0] cmd_tag_in,
  output logic            cmd_ready_out,
  input  logic            abort_in,
  output logic            disp_start_out,
  input  logic            disp_ack_in,
  input  logic            disp_finished_in,
  input  logic [7:0]      cluster_busy_in,
  output logic            coll_start_out,
  input  logic            coll_done_in,
  output logic            done_out,
  output logic [TAGW-1:0] done_tag_out,
  output logic            error_out,
  output logic [15:0]     op_count_out,
  output logic [2:0]      state_out
);

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_START    = 3'd1,
    SEQ_DISPATCH = 3'd2,
    SEQ_DRAIN    = 3'd3,
    SEQ_COLLECT  = 3'd4,
    SEQ_DONE     = 3'd5,
    SEQ_ERROR    = 3'd6
  } seq_state_t;

  seq_state_t      r_state;
  logic [TAGW-1:0] r_tag;
  logic [TAGW-1:0] r_done_tag;
  logic [7:0]      r_drain_cnt;
  logic [15:0]     r_wdog;
  logic [15:0]     r_op_count;

  logic w_wait_state;
  logic w_wdog_expired;
  logic w_cluster_idle;

  // The watchdog only runs in the states that wait on an external partner.
  assign w_wait_state   = (r_state == SEQ_START)    || (r_state == SEQ_DISPATCH) ||
                          (r_state == SEQ_DRAIN)    || (r_state == SEQ_COLLECT);
  assign w_wdog_expired = w_wait_state && (r_wdog == 16'(TIMEOUT - 1));
  assign w_cluster_idle = (cluster_busy_in == 8'h00);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SEQ_IDLE;
      r_tag       <= '0;
      r_done_tag  <= '0;
      r_drain_cnt <= '0;
      r_wdog      <= '0;
      r_op_count  <= '0;
    end else if (abort_in && (r_state != SEQ_IDLE)) begin
      r_state     <= SEQ_IDLE;
      r_drain_cnt <= '0;
      r_wdog      <= '0;
    end else if (w_wdog_expired) begin
      r_state    <= SEQ_ERROR;
      r_done_tag <= r_tag;
      r_wdog     <= '0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          r_wdog <= '0;
          if (cmd_valid_in) begin
            r_tag   <= cmd_tag_in;
            r_state <= SEQ_START;
          end
        end
        SEQ_START: begin
          if (disp_ack_in) begin
            r_state <= SEQ_DISPATCH;
            r_wdog  <= '0;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
        end
        SEQ_DISPATCH: begin
          if (disp_finished_in) begin
            r_state     <= SEQ_DRAIN;
            r_drain_cnt <= '0;
            r_wdog      <= '0;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
        end
        SEQ_DRAIN: begin
          // A busy unit restarts the idle run but not the watchdog.
          if (!w_cluster_idle) begin
            r_drain_cnt <= '0;
            r_wdog      <= r_wdog + 16'd1;
          end else if (r_drain_cnt == 8'(DRAIN_CYCLES - 1)) begin
            r_state     <= SEQ_COLLECT;
            r_drain_cnt <= '0;
            r_wdog      <= '0;
          end else begin
            r_drain_cnt <= r_drain_cnt + 8'd1;
            r_wdog      <= r_wdog + 16'd1;
          end
        end
        SEQ_COLLECT: begin
          if (coll_done_in) begin
            r_state    <= SEQ_DONE;
            r_done_tag <= r_tag;
            r_wdog     <= '0;
          end else begin
            r_wdog <= r_wdog + 16'd1;
          end
        end
        SEQ_DONE: begin
          if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
          r_state <= SEQ_IDLE;
        end
        SEQ_ERROR: begin
          r_state <= SEQ_ERROR;
        end
        default: begin
          r_state <= SEQ_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_out  = (r_state == SEQ_IDLE);
  assign disp_start_out = (r_state == SEQ_START);
  assign coll_start_out = (r_state == SEQ_COLLECT);
  assign done_out       = (r_state == SEQ_DONE);
  assign error_out      = (r_state == SEQ_ERROR);
  assign done_tag_out   = r_done_tag;
  assign op_count_out   = r_op_count;
  assign state_out      = r_state;

endmodule

// File: tb/tb_mpu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mpu_op_sequencer
//   Directed bench for mpu_op_sequencer with DRAIN_CYCLES=4, TIMEOUT=16.
//   Inputs change #1 after the rising edge; outputs are checked at the same
//   point, i.e. they reflect the state registered on that edge.
// ---------------------------------------------------------------------------
module tb_mpu_op_sequencer;

  localparam int TAGW = 4;

  logic            clk;
  logic            rst;
  logic            cmd_valid_in;
  logic [TAGW-1:0] cmd_tag_in;
  logic            cmd_ready_out;
  logic            abort_in;
  logic            disp_start_out;
  logic            disp_ack_in;
  logic            disp_finished_in;
  logic [7:0]      cluster_busy_in;
  logic            coll_start_out;
  logic            coll_done_in;
  logic            done_out;
  logic [TAGW-1:0] done_tag_out;
  logic            error_out;
  logic [15:0]     op_count_out;
  logic [2:0]      state_out;

  int n_checks = 0;
  int n_fail   = 0;

  mpu_op_sequencer #(
    .DRAIN_CYCLES(4),
    .TIMEOUT     (16),
    .TAGW        (TAGW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid_in    (cmd_valid_in),
    .cmd_tag_in      (cmd_tag_in),
    .cmd_ready_out   (cmd_ready_out),
    .abort_in        (abort_in),
    .disp_start_out  (disp_start_out),
    .disp_ack_in     (disp_ack_in),
    .disp_finished_in(disp_finished_in),
    .cluster_busy_in (cluster_busy_in),
    .coll_start_out  (coll_start_out),
    .coll_done_in    (coll_done_in),
    .done_out        (done_out),
    .done_tag_out    (done_tag_out),
    .error_out       (error_out),
    .op_count_out    (op_count_out),
    .state_out       (state_out)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send_cmd(input logic [TAGW-1:0] tag);
    cmd_valid_in = 1'b1;
    cmd_tag_in   = tag;
    step();
    cmd_valid_in = 1'b0;
  endtask

  task automatic ack_dispatch();
    disp_ack_in = 1'b1;
    step();
    disp_ack_in = 1'b0;
  endtask

  task automatic finish_dispatch();
    disp_finished_in = 1'b1;
    step();
    disp_finished_in = 1'b0;
  endtask

  // From DRAIN with an idle cluster: 4 cycles to COLLECT.
  task automatic idle_drain();
    cluster_busy_in = 8'h00;
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic collect_done();
    coll_done_in = 1'b1;
    step();
    coll_done_in = 1'b0;
  endtask

  localparam logic [7:0] DRAIN_PAT [8] = '{8'h00, 8'h00, 8'h00, 8'h10,
                                           8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    rst = 1'b1; cmd_valid_in = 1'b0; cmd_tag_in = '0; abort_in = 1'b0;
    disp_ack_in = 1'b0; disp_finished_in = 1'b0; cluster_busy_in = 8'h00;
    coll_done_in = 1'b0;
    step(); step();
    rst = 1'b0;

    // ---- reset state
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_ready", 32'(cmd_ready_out), 32'd1);
    chk("rst_disp_start", 32'(disp_start_out), 32'd0);
    chk("rst_coll_start", 32'(coll_start_out), 32'd0);
    chk("rst_done", 32'(done_out), 32'd0);
    chk("rst_error", 32'(error_out), 32'd0);
    chk("rst_tag", 32'(done_tag_out), 32'd0);
    chk("rst_opcnt", 32'(op_count_out), 32'd0);

    // ---- nominal flow, tag 0x5
    send_cmd(4'h5);
    chk("nom_start_state", 32'(state_out), 32'd1);
    chk("nom_disp_start", 32'(disp_start_out), 32'd1);
    chk("nom_ready_low", 32'(cmd_ready_out), 32'd0);
    ack_dispatch();
    chk("nom_dispatch_state", 32'(state_out), 32'd2);
    chk("nom_disp_start_drop", 32'(disp_start_out), 32'd0);
    for (int i = 0; i < 9; i++) begin
      chk("nom_dispatch_hold", 32'(state_out), 32'd2);
      step();
    end
    finish_dispatch();
    for (int i = 0; i < 4; i++) begin
      chk("nom_drain_hold", 32'(state_out), 32'd3);
      step();
    end
    chk("nom_collect_state", 32'(state_out), 32'd4);
    chk("nom_coll_start", 32'(coll_start_out), 32'd1);
    step(); step();
    chk("nom_coll_held", 32'(coll_start_out), 32'd1);
    collect_done();
    chk("nom_done_state", 32'(state_out), 32'd5);
    chk("nom_done_pulse", 32'(done_out), 32'd1);
    chk("nom_done_tag", 32'(done_tag_out), 32'h5);
    step();
    chk("nom_back_idle", 32'(state_out), 32'd0);
    chk("nom_done_low", 32'(done_out), 32'd0);
    chk("nom_opcnt", 32'(op_count_out), 32'd1);
    chk("nom_tag_kept", 32'(done_tag_out), 32'h5);

    // ---- drain restart, tag 0x6
    send_cmd(4'h6);
    ack_dispatch();
    finish_dispatch();
    for (int i = 0; i < 8; i++) begin
      chk("drn_hold", 32'(state_out), 32'd3);
      cluster_busy_in = DRAIN_PAT[i];
      step();
    end
    cluster_busy_in = 8'h00;
    chk("drn_collect_after_8", 32'(state_out), 32'd4);
    collect_done();
    step();
    chk("drn_opcnt", 32'(op_count_out), 32'd2);

    // ---- timeout in START, tag 0xA
    send_cmd(4'hA);
    for (int i = 0; i < 16; i++) begin
      chk("to_start_hold", 32'(state_out), 32'd1);
      step();
    end
    chk("to_error_state", 32'(state_out), 32'd6);
    chk("to_error_flag", 32'(error_out), 32'd1);
    chk("to_disp_start_low", 32'(disp_start_out), 32'd0);
    chk("to_err_tag", 32'(done_tag_out), 32'hA);
    cmd_valid_in = 1'b1;
    cmd_tag_in   = 4'h1;
    step(); step(); step();
    cmd_valid_in = 1'b0;
    chk("to_error_stuck", 32'(state_out), 32'd6);
    chk("to_ready_low", 32'(cmd_ready_out), 32'd0);
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
    chk("to_abort_idle", 32'(state_out), 32'd0);
    chk("to_abort_err_clr", 32'(error_out), 32'd0);
    chk("to_abort_opcnt", 32'(op_count_out), 32'd2);

    // ---- abort in the same cycle as coll_done, tag 0xB
    send_cmd(4'hB);
    ack_dispatch();
    finish_dispatch();
    idle_drain();
    chk("ab_collect_state", 32'(state_out), 32'd4);
    abort_in     = 1'b1;
    coll_done_in = 1'b1;
    step();
    abort_in     = 1'b0;
    coll_done_in = 1'b0;
    chk("ab_idle", 32'(state_out), 32'd0);
    chk("ab_no_done", 32'(done_out), 32'd0);
    step();
    chk("ab_no_done_later", 32'(done_out), 32'd0);
    chk("ab_opcnt", 32'(op_count_out), 32'd2);
    chk("ab_tag_unchanged", 32'(done_tag_out), 32'hA);

    // ---- commands while busy are ignored, tag 0x9 then 0x3
    send_cmd(4'h9);
    cmd_valid_in = 1'b1;
    cmd_tag_in   = 4'h3;
    ack_dispatch();
    finish_dispatch();
    idle_drain();
    collect_done();
    chk("busy_done_tag9", 32'(done_tag_out), 32'h9);
    step();
    chk("busy_idle", 32'(state_out), 32'd0);
    chk("busy_opcnt1", 32'(op_count_out), 32'd3);
    step();
    cmd_valid_in = 1'b0;
    chk("busy_second_start", 32'(state_out), 32'd1);
    ack_dispatch();
    finish_dispatch();
    idle_drain();
    collect_done();
    chk("busy_done_tag3", 32'(done_tag_out), 32'h3);
    step();
    chk("busy_opcnt2", 32'(op_count_out), 32'd4);

    // ---- reset mid-operation in DRAIN, tag 0xC
    send_cmd(4'hC);
    ack_dispatch();
    finish_dispatch();
    cluster_busy_in = 8'hFF;
    step();
    chk("mr_in_drain", 32'(state_out), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cluster_busy_in = 8'h00;
    chk("mr_state", 32'(state_out), 32'd0);
    chk("mr_ready", 32'(cmd_ready_out), 32'd1);
    chk("mr_opcnt", 32'(op_count_out), 32'd0);
    chk("mr_tag", 32'(done_tag_out), 32'd0);
    chk("mr_coll_start", 32'(coll_start_out), 32'd0);
    chk("mr_error", 32'(error_out), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
